apb_mem_slave: RTL and testbench
================================

# apb_mem_slave

Parametrised APB memory-mapped slave with a register-file backing store, configurable wait states, byte-lane writes and error signalling. Sits behind the APB master/bridge as the generic target for bus-level verification and as a scratchpad peripheral. Generalises the fixed 8-bit × 32-entry slave in four ways:
- configurable data width, address width and depth;
- wait-state insertion;
- address-range and alignment checking with PSLVERR;
- clean abort when PSEL drops mid-access.

## Interface
Parameters:
- DATA_W, 32: data bus width. Must be 8, 16, 32 or 64.
- ADDR_W, 8: PADDR width, byte address.
- DEPTH, 16: number of DATA_W words. DEPTH ≤ 2^(ADDR_W−ADDR_LSB), where ADDR_LSB = log2(DATA_W/8).
- WAIT_CYCLES, 0: wait states inserted per transfer, range 0–15.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  DATA_W  write data.
- PSTRB  in  DATA_W/8  byte-lane enables. Present only with APB_SLV_STRB_EN.
- PREADY  out  1  transfer complete. Registered.
- PRDATA  out  DATA_W  read data. Valid only while PREADY=1 on a read. Registered.
- PSLVERR  out  1  error response. Valid only while PREADY=1. Registered.

## Operation
- FSM has two states, IDLE and ACCESS.
- In IDLE, a setup cycle is PSEL=1 and PENABLE=0. On a setup cycle the slave:
  - latches PADDR, PWRITE, PWDATA and PSTRB;
  - loads the wait counter with WAIT_CYCLES;
  - evaluates the error condition;
  - moves to ACCESS.
- Error condition, either of:
  - PADDR[ADDR_LSB−1:0] ≠ 0 (misaligned);
  - word index PADDR[ADDR_W−1:ADDR_LSB] ≥ DEPTH (out of range).
- In ACCESS, with PSEL=1 and PENABLE=1:
  - if the counter is nonzero, it decrements each cycle;
  - when the counter is zero, PREADY is driven 1 from the next edge.
- Completion is the edge at which PSEL, PENABLE and PREADY are all 1. At completion:
  - write without error: memory word updated. With strobes, only lanes with PSTRB[i]=1 change.
  - error: no memory change and PSLVERR=1. On a read, PRDATA=0.
  - the FSM returns to IDLE, and PREADY, PSLVERR and PRDATA clear to 0 at that edge.
- Read data: PRDATA is loaded from memory at the same edge that raises PREADY. PSLVERR is loaded at that same edge.
- Abort: PSEL=0 while in ACCESS sends the FSM to IDLE. No write occurs and the outputs clear.
- Protocol violation: PSEL=1 and PENABLE=0 while in ACCESS is treated as a fresh setup cycle. The old transfer is dropped with no write.
- Back-to-back: a setup cycle immediately after completion is accepted, giving zero idle cycles.

## Timing
- Reset (asynchronous, while Rst=1):
  - PREADY=0, PSLVERR=0, PRDATA=0;
  - FSM=IDLE, counter=0;
  - all memory words = 0.
- Reset asserted mid-transfer aborts it with no write. The first transfer after release needs a fresh setup cycle.
- Transfer length is 1 setup + (WAIT_CYCLES+1) access cycles. PREADY is high only in the final access cycle.
- With WAIT_CYCLES=0, PREADY=1 in the first access cycle, i.e. the classic 2-cycle transfer.
- Write data becomes visible to a read whose setup cycle follows the write's completion cycle.
- No combinational path from any input to any output.

## Configuration
- Macro: APB_SLV_STRB_EN.
- Defined:
  - PSTRB port is present;
  - writes are byte-masked;
  - a write with PSTRB=0 completes OKAY and changes nothing.
- Undefined:
  - no PSTRB port;
  - every write updates the full word;
  - all other behaviour is identical.

## Structure
- Package apb_slv_pkg holds:
  - state_t enum {IDLE, ACCESS};
  - function addr_lsb(DATA_W);
  - WAIT_W = 4 (counter width).
- Sub-module apb_slv_mem holds the DEPTH × DATA_W array:
  - synchronous write with byte-lane enable;
  - synchronous read;
  - asynchronous reset to zero.
- apb_mem_slave contains the FSM, address checking, wait counter and output registers.

## Test plan
Bench configuration: DATA_W=32, ADDR_W=8, DEPTH=16.
1. WAIT_CYCLES=0: write 0xDEADBEEF to 0x04, then read 0x04. Each transfer is 2 cycles, PREADY is high for 1 cycle, read returns PRDATA=0xDEADBEEF and PSLVERR=0.
2. WAIT_CYCLES=2: read 0x00 after reset. PREADY goes high in the 3rd access cycle, PRDATA=0x00000000.
3. Write to 0x40 (index 16, out of range) and read 0x06 (misaligned). Both return PSLVERR=1 with PREADY. Memory is unchanged, and the read returns PRDATA=0.
4. STRB_EN: write 0xFFFFFFFF to 0x08, then write 0x00000000 with PSTRB=4'b0101. A read of 0x08 returns 0xFF00FF00.
5. WAIT_CYCLES=3: drop PSEL after 1 access cycle of a write 0x12345678 to 0x0C. PREADY never rises and a later read of 0x0C returns 0.
6. Assert Rst during the access phase of a write. Outputs go to 0 immediately, the write is lost, and back-to-back transfers after release complete normally.

Source files
------------

// File: rtl/apb_slv_pkg.sv
// apb_slv_pkg -- shared types and helpers for the APB memory slave.
// Holds the two-state transfer FSM encoding, the wait-counter width and
// the byte-address to word-address shift helper.
package apb_slv_pkg;

  // Transfer FSM: IDLE waits for a setup cycle, ACCESS runs the access phase.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Wait-state counter width; covers WAIT_CYCLES 0..15.
  localparam int WAIT_W = 4;

  // Number of byte-offset bits below the word index for a given data width.
  function automatic int addr_lsb(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage : apb_slv_pkg

// File: rtl/apb_slv_mem.sv
// apb_slv_mem -- DEPTH x DATA_W register-file backing store.
// Synchronous byte-lane write, synchronous read into a registered output
// that returns zero on any cycle without a read request, and asynchronous
// reset of every word to zero.
module apb_slv_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4
) (
  input  logic                CLK,
  input  logic                Rst,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [DATA_W-1:0]   rd_data
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array: byte-masked write, whole array cleared on reset.
  // NOTE: the array is reset because software relies on a zeroed
  // scratchpad; that only suits a small flop-based store -- an SRAM macro
  // could not be cleared this way.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read register: loads the addressed word on request, otherwise zero,
  // so it doubles as the bus read-data register.
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_en ? mem[rd_idx] : '0;
    end
  end

endmodule : apb_slv_mem

// File: rtl/apb_mem_slave.sv
// apb_mem_slave -- parametrised APB memory-mapped slave.
// Two-state transfer FSM, alignment/range checking with PSLVERR, a
// programmable wait-state counter and registered PREADY/PSLVERR/PRDATA.
// A setup cycle (PSEL=1, PENABLE=0) is accepted in any state, which gives
// back-to-back transfers and restarts a transfer on a protocol violation.
// Optional feature macro: APB_SLV_STRB_EN adds the PSTRB byte-lane port;
// without it every write updates the full word.
module apb_mem_slave
  import apb_slv_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                CLK,
  input  logic                Rst,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
`ifdef APB_SLV_STRB_EN
  input  logic [DATA_W/8-1:0] PSTRB,
`endif
  output logic                PREADY,
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PSLVERR
);

  localparam int NB       = DATA_W / 8;
  localparam int ADDR_LSB = addr_lsb(DATA_W);
  localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Byte-offset mask (zero for an 8-bit bus, where every address is aligned).
  localparam logic [ADDR_W-1:0] LSB_MASK  = ADDR_W'((1 << ADDR_LSB) - 1);
  // One extra bit so DEPTH == 2^ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);
  localparam logic              NO_WAIT   = (WAIT_CYCLES == 0);

  state_t            state;
  logic [WAIT_W-1:0] cnt;

  // Transfer attributes captured at the setup cycle.
  logic [IDX_W-1:0]  lat_idx;
  logic              lat_write;
  logic              lat_err;
  logic [DATA_W-1:0] lat_wdata;
  logic [NB-1:0]     lat_be;

  // Decode of the current bus address.
  logic [ADDR_W-1:0] word_full;
  logic              err_now;
  logic [NB-1:0]     be_now;

  // Phase qualifiers.
  logic setup;
  logic access_on;
  logic complete;
  logic raise;

  // Memory port controls.
  logic              wr_en;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_idx;

`ifdef APB_SLV_STRB_EN
  assign be_now = PSTRB;
`else
  assign be_now = '1;
`endif

  // Address check: misaligned byte offset or word index beyond DEPTH.
  // NOTE: every variable is assigned on every path through this block, so
  // it stays purely combinational and no latch is inferred.
  always_comb begin
    word_full = PADDR >> ADDR_LSB;
    err_now   = ((PADDR & LSB_MASK) != '0) || ({1'b0, word_full} >= DEPTH_LIM);
  end

  assign setup     = PSEL && !PENABLE;
  assign access_on = (state == ACCESS) && PSEL && PENABLE;
  assign complete  = access_on && PREADY;
  // The edge at which the counter runs out raises PREADY for the final
  // access cycle; with no wait states that edge is the setup edge itself.
  assign raise     = access_on && !PREADY && (cnt <= WAIT_W'(1));

  assign wr_en  = complete && lat_write && !lat_err;
  assign rd_en  = (setup && NO_WAIT && !PWRITE && !err_now) ||
                  (raise && !lat_write && !lat_err);
  assign rd_idx = setup ? word_full[IDX_W-1:0] : lat_idx;

  // Transfer FSM with wait counter and registered PREADY/PSLVERR.
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
      lat_idx   <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else if (setup) begin
      // Fresh setup: accepted from IDLE, right after completion, or as a
      // restart that silently drops an unfinished transfer.
      state     <= ACCESS;
      cnt       <= WAIT_LOAD;
      lat_idx   <= word_full[IDX_W-1:0];
      lat_write <= PWRITE;
      lat_err   <= err_now;
      lat_wdata <= PWDATA;
      lat_be    <= be_now;
      PREADY    <= NO_WAIT;
      PSLVERR   <= NO_WAIT && err_now;
    end else if (state == ACCESS) begin
      if (!PSEL || complete) begin
        // Abort or completion: back to IDLE with outputs cleared.
        state   <= IDLE;
        cnt     <= '0;
        PREADY  <= 1'b0;
        PSLVERR <= 1'b0;
      end else if (raise) begin
        cnt     <= '0;
        PREADY  <= 1'b1;
        PSLVERR <= lat_err;
      end else if (access_on && !PREADY) begin
        cnt <= cnt - WAIT_W'(1);
      end
    end
  end

  apb_slv_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .CLK     (CLK),
    .Rst     (Rst),
    .wr_en   (wr_en),
    .wr_idx  (lat_idx),
    .wr_be   (lat_be),
    .wr_data (lat_wdata),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx),
    .rd_data (PRDATA)
  );

endmodule : apb_mem_slave

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave -- bench for apb_mem_slave with DATA_W=32, ADDR_W=8,
// DEPTH=16. Three instances (WAIT_CYCLES 0, 2, 3) share the bus apart from
// PSEL. The driver knows the APB transfer timing and publishes the outputs
// every instance must show in each cycle; a word-array model supplies read
// data. Literal values pin the directed cases.
module tb_apb_mem_slave;

  localparam int NDUT = 3;
  localparam int W0 = 0;
  localparam int W1 = 2;
  localparam int W2 = 3;

  logic              CLK = 1'b0;
  logic              Rst;
  logic [NDUT-1:0]   psel;
  logic              PENABLE;
  logic              PWRITE;
  logic [7:0]        PADDR;
  logic [31:0]       PWDATA;
`ifdef APB_SLV_STRB_EN
  logic [3:0]        PSTRB;
`endif
  logic              pready  [NDUT];
  logic [31:0]       prdata  [NDUT];
  logic              pslverr [NDUT];

  logic              exp_ready [NDUT];
  logic [31:0]       exp_rdata [NDUT];
  logic              exp_err   [NDUT];
  logic [31:0]       model_mem [NDUT][16];

  logic              check_en = 1'b0;
  int                total = 0;
  int                bad   = 0;

  always #5 CLK = ~CLK;

  apb_mem_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .WAIT_CYCLES(W0)) u_w0 (
    .CLK(CLK), .Rst(Rst), .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_SLV_STRB_EN
    .PSTRB(PSTRB),
`endif
    .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));

  apb_mem_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .WAIT_CYCLES(W1)) u_w2 (
    .CLK(CLK), .Rst(Rst), .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_SLV_STRB_EN
    .PSTRB(PSTRB),
`endif
    .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));

  apb_mem_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .WAIT_CYCLES(W2)) u_w3 (
    .CLK(CLK), .Rst(Rst), .PSEL(psel[2]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_SLV_STRB_EN
    .PSTRB(PSTRB),
`endif
    .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int wait_of(input int k);
    case (k)
      0:       return W0;
      1:       return W1;
      default: return W2;
    endcase
  endfunction

  // Slave error rule: not word aligned, or word index 16 or more.
  function automatic bit addr_err(input logic [7:0] a);
    return ((int'(a) % 4) != 0) || ((int'(a) / 4) >= 16);
  endfunction

  // Lanes a write actually changes.
  function automatic logic [3:0] lanes(input logic [3:0] s);
`ifdef APB_SLV_STRB_EN
    return s;
`else
    return s | 4'hF;
`endif
  endfunction

  task automatic clear_exp();
    for (int k = 0; k < NDUT; k++) begin
      exp_ready[k] = 1'b0;
      exp_rdata[k] = '0;
      exp_err[k]   = 1'b0;
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < NDUT; k++)
      for (int i = 0; i < 16; i++)
        model_mem[k][i] = '0;
  endtask

  task automatic drive_idle();
    psel    = '0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
`ifdef APB_SLV_STRB_EN
    PSTRB   = '0;
`endif
  endtask

  // Every task is entered just after a rising edge and returns just after
  // one, so the caller drives the next cycle immediately.
  task automatic idle(input int n);
    repeat (n) begin
      drive_idle();
      clear_exp();
      @(posedge CLK); #1;
    end
  endtask

  // One transfer on instance k. cut_at (1..WAIT) stops the transfer at that
  // access cycle and hands the bus back to the caller (abort or restart).
  task automatic xfer(input int k, input bit wr, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] s, input int cut_at,
                      input bit lit_en, input logic [31:0] lit_data, input bit lit_err);
    int w;
    bit e;
    int idx;
    logic [3:0] be;
    w   = wait_of(k);
    e   = addr_err(a);
    idx = int'(a) / 4;
    be  = lanes(s);
    psel    = '0;
    psel[k] = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = a;
    PWDATA  = d;
`ifdef APB_SLV_STRB_EN
    PSTRB   = s;
`endif
    clear_exp();
    for (int j = 1; j <= w + 1; j++) begin
      @(posedge CLK); #1;
      if (j == cut_at) return;
      PENABLE = 1'b1;
      clear_exp();
      if (j == w + 1) begin
        exp_ready[k] = 1'b1;
        exp_err[k]   = e;
        exp_rdata[k] = (!wr && !e) ? model_mem[k][idx % 16] : 32'h0;
        if (lit_en) begin
          @(negedge CLK); #1;
          check($sformatf("lit_pready%0d_a%h", k, a), pready[k], 1'b1);
          check($sformatf("lit_pslverr%0d_a%h", k, a), pslverr[k], lit_err);
          if (!wr) check($sformatf("lit_prdata%0d_a%h", k, a), prdata[k], lit_data);
        end
      end
    end
    @(posedge CLK); #1;
    if (wr && !e) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) model_mem[k][idx][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // Per-cycle compare of every instance against the published expectation.
  always @(negedge CLK) begin
    if (check_en) begin
      for (int k = 0; k < NDUT; k++) begin
        check($sformatf("pready%0d", k), pready[k], exp_ready[k]);
        check($sformatf("pslverr%0d", k), pslverr[k], exp_err[k]);
        check($sformatf("prdata%0d", k), prdata[k], exp_rdata[k]);
      end
    end
  end

  initial begin
    Rst = 1'b1;
    drive_idle();
    clear_exp();
    clear_model();
    check_en = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    Rst = 1'b0;
    idle(1);

    // 1: two-cycle write then read.
    xfer(0, 1, 8'h04, 32'hDEADBEEF, 4'hF, 0, 1, 32'h0, 1'b0);
    xfer(0, 0, 8'h04, 32'h0, 4'hF, 0, 1, 32'hDEADBEEF, 1'b0);
    idle(1);

    // 2: two wait states, read of a reset word.
    xfer(1, 0, 8'h00, 32'h0, 4'hF, 0, 1, 32'h0, 1'b0);

    // 3: out-of-range write and misaligned read on both wait settings.
    xfer(0, 1, 8'h00, 32'hCAFEF00D, 4'hF, 0, 0, 32'h0, 1'b0);
    xfer(0, 1, 8'h40, 32'h55555555, 4'hF, 0, 1, 32'h0, 1'b1);
    xfer(0, 0, 8'h00, 32'h0, 4'hF, 0, 1, 32'hCAFEF00D, 1'b0);
    xfer(0, 0, 8'h06, 32'h0, 4'hF, 0, 1, 32'h0, 1'b1);
    xfer(1, 1, 8'h40, 32'h55555555, 4'hF, 0, 1, 32'h0, 1'b1);
    xfer(1, 0, 8'h06, 32'h0, 4'hF, 0, 1, 32'h0, 1'b1);
    xfer(1, 0, 8'h00, 32'h0, 4'hF, 0, 1, 32'h0, 1'b0);
    xfer(1, 0, 8'hFC, 32'h0, 4'hF, 0, 1, 32'h0, 1'b1);
    idle(1);

    // 4: byte lanes, including an all-zero strobe.
    xfer(0, 1, 8'h08, 32'hFFFFFFFF, 4'hF, 0, 0, 32'h0, 1'b0);
    xfer(0, 1, 8'h08, 32'h00000000, 4'b0101, 0, 0, 32'h0, 1'b0);
`ifdef APB_SLV_STRB_EN
    xfer(0, 0, 8'h08, 32'h0, 4'hF, 0, 1, 32'hFF00FF00, 1'b0);
    xfer(0, 1, 8'h08, 32'h12345678, 4'h0, 0, 1, 32'h0, 1'b0);
    xfer(0, 0, 8'h08, 32'h0, 4'hF, 0, 1, 32'hFF00FF00, 1'b0);
`else
    xfer(0, 0, 8'h08, 32'h0, 4'hF, 0, 1, 32'h00000000, 1'b0);
    xfer(0, 1, 8'h08, 32'h12345678, 4'h0, 0, 1, 32'h0, 1'b0);
    xfer(0, 0, 8'h08, 32'h0, 4'hF, 0, 1, 32'h12345678, 1'b0);
`endif

    // Restart mid-access: the dropped write must not land.
    xfer(1, 1, 8'h14, 32'h11111111, 4'hF, 2, 0, 32'h0, 1'b0);
    xfer(1, 0, 8'h14, 32'h0, 4'hF, 0, 1, 32'h0, 1'b0);
    xfer(1, 1, 8'h18, 32'h89ABCDEF, 4'hF, 0, 0, 32'h0, 1'b0);
    xfer(1, 0, 8'h18, 32'h0, 4'hF, 0, 1, 32'h89ABCDEF, 1'b0);

    // 5: PSEL dropped after one access cycle of a three-wait write.
    xfer(2, 1, 8'h0C, 32'h12345678, 4'hF, 2, 0, 32'h0, 1'b0);
    idle(2);
    xfer(2, 0, 8'h0C, 32'h0, 4'hF, 0, 1, 32'h0, 1'b0);
    xfer(2, 1, 8'h3C, 32'hA1B2C3D4, 4'hF, 0, 0, 32'h0, 1'b0);
    xfer(2, 0, 8'h3C, 32'h0, 4'hF, 0, 1, 32'hA1B2C3D4, 1'b0);

    // 6: reset during the ready cycle of a write.
    psel    = '0;
    psel[0] = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = 1'b1;
    PADDR   = 8'h10;
    PWDATA  = 32'hA5A5A5A5;
`ifdef APB_SLV_STRB_EN
    PSTRB   = 4'hF;
`endif
    clear_exp();
    @(posedge CLK); #1;
    PENABLE = 1'b1;
    check("t6_pready_before_reset", pready[0], 1'b1);
    Rst = 1'b1;
    clear_exp();
    clear_model();
    #1;
    check("t6_pready_async", pready[0], 1'b0);
    @(posedge CLK); #1;
    drive_idle();
    @(posedge CLK); #1;
    Rst = 1'b0;
    xfer(0, 0, 8'h10, 32'h0, 4'hF, 0, 1, 32'h0, 1'b0);
    xfer(0, 0, 8'h04, 32'h0, 4'hF, 0, 1, 32'h0, 1'b0);
    xfer(0, 1, 8'h10, 32'h0BADCAFE, 4'hF, 0, 0, 32'h0, 1'b0);
    xfer(0, 0, 8'h10, 32'h0, 4'hF, 0, 1, 32'h0BADCAFE, 1'b0);
    xfer(2, 0, 8'h3C, 32'h0, 4'hF, 0, 1, 32'h0, 1'b0);
    xfer(1, 1, 8'h20, 32'h600DF00D, 4'hF, 0, 0, 32'h0, 1'b0);
    xfer(1, 0, 8'h20, 32'h0, 4'hF, 0, 1, 32'h600DF00D, 1'b0);
    idle(2);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_apb_mem_slave
